// File: rtl/offchip_mem_responder_pkg.sv
// Shared definitions for the off-chip line responder: FSM states, word size
// and beat-count derivation from the line size.
package offchip_mem_responder_pkg;

  localparam int unsigned OFM_WORD_W             = 32;
  localparam int unsigned OFM_WORD_BYTES         = OFM_WORD_W / 8;
  localparam int unsigned OFM_DEFAULT_LINE_BYTES = 32;

  typedef enum logic [2:0] {
    OFM_IDLE,
    OFM_RD,
    OFM_WR,
    OFM_DONE,
    OFM_RELEASE
  } ofm_state_t;

  function automatic int unsigned ofm_beats(input int unsigned line_bytes);
    return line_bytes / OFM_WORD_BYTES;
  endfunction

endpackage

// File: rtl/offchip_line_buf.sv
// Line storage for the responder: a write line loaded in parallel and read
// one word at a time, plus a read line captured one word at a time.
module offchip_line_buf
  import offchip_mem_responder_pkg::*;
#(
  parameter int unsigned LINE_BYTES = OFM_DEFAULT_LINE_BYTES,
  parameter int unsigned BEATS      = LINE_BYTES / OFM_WORD_BYTES,
  parameter int unsigned IDX_W      = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [LINE_BYTES*8-1:0] load_line,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [OFM_WORD_W-1:0]   rd_word,
  input  logic                    cap_en,
  input  logic [IDX_W-1:0]        cap_idx,
  input  logic [OFM_WORD_W-1:0]   cap_word,
  output logic [LINE_BYTES*8-1:0] cap_line
);

  logic [BEATS-1:0][OFM_WORD_W-1:0] wline;
  logic [BEATS-1:0][OFM_WORD_W-1:0] rline;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wline <= '0;
    end else if (load) begin
      wline <= load_line;
    end
  end

  // Read capture is kept separate so a write never disturbs the last read line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rline <= '0;
    end else if (cap_en) begin
      rline[cap_idx] <= cap_word;
    end
  end

  assign rd_word  = wline[rd_idx];
  assign cap_line = rline;

endmodule

// File: rtl/offchip_mem_responder.sv
// Responder for the cache-line off-chip channel: splits one line read or
// write into 32-bit SRAM beats and signals completion with a one-cycle pulse.
module offchip_mem_responder
  import offchip_mem_responder_pkg::*;
#(
  parameter int unsigned LINE_BYTES = OFM_DEFAULT_LINE_BYTES,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       offchip_mem_addr,
  input  logic                    offchip_mem_read_en,
  input  logic                    offchip_mem_write_en,
  input  logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
  output logic [LINE_BYTES*8-1:0] offchip_mem_data,
  output logic                    offchip_mem_ready,
  output logic                    offchip_mem_read_busy,
  output logic                    offchip_mem_write_busy,
  output logic                    sram_req,
  output logic                    sram_we,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [OFM_WORD_W-1:0]   sram_wdata,
  input  logic                    sram_ack,
  input  logic [OFM_WORD_W-1:0]   sram_rdata
);

  localparam int unsigned      BEATS       = ofm_beats(LINE_BYTES);
  localparam int unsigned      CNT_W       = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] WORD_STEP   = ADDR_W'(OFM_WORD_BYTES);

  ofm_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] line_base;
  logic              accept_wr;
  logic              cap_en;

  assign line_base = offchip_mem_addr & ~OFFSET_MASK;
  assign accept_wr = (state == OFM_IDLE) && offchip_mem_write_en;
  assign cap_en    = (state == OFM_RD) && sram_ack;

  offchip_line_buf #(
    .LINE_BYTES (LINE_BYTES),
    .BEATS      (BEATS),
    .IDX_W      (CNT_W)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_wr),
    .load_line (offchip_mem_wdata),
    .rd_idx    (cnt),
    .rd_word   (sram_wdata),
    .cap_en    (cap_en),
    .cap_idx   (cnt),
    .cap_word  (sram_rdata),
    .cap_line  (offchip_mem_data)
  );

  // sram_addr is stepped by one word per ack instead of recomputing base+4*cnt;
  // the two track each other exactly and wrap identically at the top of memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= OFM_IDLE;
      cnt                    <= '0;
      sram_req               <= 1'b0;
      sram_we                <= 1'b0;
      sram_addr              <= '0;
      offchip_mem_ready      <= 1'b0;
      offchip_mem_read_busy  <= 1'b0;
      offchip_mem_write_busy <= 1'b0;
    end else begin
      offchip_mem_ready <= 1'b0;
      unique case (state)
        OFM_IDLE: begin
          if (offchip_mem_write_en) begin
            state                  <= OFM_WR;
            cnt                    <= '0;
            sram_addr              <= line_base;
            sram_req               <= 1'b1;
            sram_we                <= 1'b1;
            offchip_mem_write_busy <= 1'b1;
          end else if (offchip_mem_read_en) begin
            state                 <= OFM_RD;
            cnt                   <= '0;
            sram_addr             <= line_base;
            sram_req              <= 1'b1;
            sram_we               <= 1'b0;
            offchip_mem_read_busy <= 1'b1;
          end
        end
        OFM_RD, OFM_WR: begin
          if (sram_ack) begin
            if (cnt == LAST_BEAT) begin
              state                  <= OFM_DONE;
              sram_req               <= 1'b0;
              sram_we                <= 1'b0;
              offchip_mem_read_busy  <= 1'b0;
              offchip_mem_write_busy <= 1'b0;
              offchip_mem_ready      <= 1'b1;
            end else begin
              cnt       <= cnt + 1'b1;
              sram_addr <= sram_addr + WORD_STEP;
            end
          end
        end
        OFM_DONE: begin
          state <= OFM_RELEASE;
        end
        OFM_RELEASE: begin
          if (!offchip_mem_read_en && !offchip_mem_write_en) begin
            state <= OFM_IDLE;
          end
        end
        default: begin
          state <= OFM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_offchip_mem_responder.sv
// Directed bench for offchip_mem_responder: SRAM model returns word[a]=a,
// beats and ready pulses are logged on the falling edge.
module tb_offchip_mem_responder;

  localparam int unsigned LB = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = LB * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] offchip_mem_addr;
  logic          offchip_mem_read_en;
  logic          offchip_mem_write_en;
  logic [LW-1:0] offchip_mem_wdata;
  logic [LW-1:0] offchip_mem_data;
  logic          offchip_mem_ready;
  logic          offchip_mem_read_busy;
  logic          offchip_mem_write_busy;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic          sram_ack;
  logic [31:0]   sram_rdata;

  always #5 clk = ~clk;

  offchip_mem_responder #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .offchip_mem_addr       (offchip_mem_addr),
    .offchip_mem_read_en    (offchip_mem_read_en),
    .offchip_mem_write_en   (offchip_mem_write_en),
    .offchip_mem_wdata      (offchip_mem_wdata),
    .offchip_mem_data       (offchip_mem_data),
    .offchip_mem_ready      (offchip_mem_ready),
    .offchip_mem_read_busy  (offchip_mem_read_busy),
    .offchip_mem_write_busy (offchip_mem_write_busy),
    .sram_req               (sram_req),
    .sram_we                (sram_we),
    .sram_addr              (sram_addr),
    .sram_wdata             (sram_wdata),
    .sram_ack               (sram_ack),
    .sram_rdata             (sram_rdata)
  );

  assign sram_rdata = sram_addr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM ack model: mode 0 always acks, mode 1 acks every third cycle.
  int ack_mode = 0;
  int phase    = 0;
  initial sram_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    phase    = (phase == 2) ? 0 : phase + 1;
    sram_ack = (ack_mode == 0) ? 1'b1 : (phase == 2);
  end

  logic [31:0] log_addr [0:63];
  logic        log_we   [0:63];
  logic [31:0] log_wd   [0:63];
  int nb = 0, ready_cnt = 0, wide = 0, rb_cnt = 0, wb_cnt = 0, unstable = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_wd = '0, prev_ad = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (sram_req && sram_ack) begin
        if (nb < 64) begin
          log_addr[nb] = sram_addr;
          log_we[nb]   = sram_we;
          log_wd[nb]   = sram_wdata;
        end
        nb++;
      end
      if (sram_req && prev_req && !prev_ack &&
          (sram_wdata !== prev_wd || sram_addr !== prev_ad)) unstable++;
      if (offchip_mem_ready) begin
        ready_cnt++;
        if (prev_ready) wide++;
      end
      if (offchip_mem_read_busy)  rb_cnt++;
      if (offchip_mem_write_busy) wb_cnt++;
    end
    prev_req   = sram_req;
    prev_ack   = sram_ack;
    prev_wd    = sram_wdata;
    prev_ad    = sram_addr;
    prev_ready = offchip_mem_ready;
  end

  task automatic clear_logs();
    @(negedge clk);
    #1;
    nb = 0; ready_cnt = 0; wide = 0; rb_cnt = 0; wb_cnt = 0; unstable = 0;
  endtask

  task automatic wait_ready(input string tag, output int cyc);
    cyc = 1;
    while (!offchip_mem_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!offchip_mem_ready) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] word_of(input logic [LW-1:0] line, input int k);
    return line[k*32 +: 32];
  endfunction

  int cyc;
  logic [LW-1:0] wline;

  initial begin
    rst = 1'b0;
    offchip_mem_addr     = '0;
    offchip_mem_read_en  = 1'b0;
    offchip_mem_write_en = 1'b0;
    offchip_mem_wdata    = '0;
    idle_cycles(3);
    chk("rst_req",   64'(sram_req), 64'd0);
    chk("rst_addr",  64'(sram_addr), 64'd0);
    chk("rst_ready", 64'(offchip_mem_ready), 64'd0);
    chk("rst_busy",  64'({offchip_mem_read_busy, offchip_mem_write_busy}), 64'd0);
    chk("rst_data",  64'(|offchip_mem_data), 64'd0);
    #1 rst = 1'b1;

    // Line read at 0x1004, ack always.
    clear_logs();
    offchip_mem_addr    = 32'h0000_1004;
    offchip_mem_read_en = 1'b1;
    wait_ready("rd1", cyc);
    chk("rd1_latency", 64'(cyc), 64'd10);
    #1 offchip_mem_read_en = 1'b0;
    idle_cycles(3);
    chk("rd1_beats", 64'(nb), 64'd8);
    chk("rd1_addr0", 64'(log_addr[0]), 64'h1000);
    chk("rd1_addr7", 64'(log_addr[7]), 64'h101C);
    chk("rd1_word0", 64'(word_of(offchip_mem_data, 0)), 64'h1000);
    chk("rd1_word7", 64'(word_of(offchip_mem_data, 7)), 64'h101C);
    chk("rd1_rbusy", 64'(rb_cnt), 64'd8);
    chk("rd1_ready", 64'(ready_cnt), 64'd1);

    // Line write at 0x2000, ack every third cycle.
    clear_logs();
    ack_mode = 1;
    for (int k = 0; k < 8; k++) wline[k*32 +: 32] = 32'h1111_1111 * (k + 1);
    offchip_mem_wdata    = wline;
    offchip_mem_addr     = 32'h0000_2000;
    offchip_mem_write_en = 1'b1;
    wait_ready("wr1", cyc);
    chk("wr1_wbusy_done", 64'(offchip_mem_write_busy), 64'd0);
    #1 offchip_mem_write_en = 1'b0;
    offchip_mem_wdata = '0;
    idle_cycles(3);
    chk("wr1_beats", 64'(nb), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wr1_addr%0d", k), 64'(log_addr[k]), 64'(32'h2000 + 4 * k));
      chk($sformatf("wr1_wd%0d", k), 64'(log_wd[k]), 64'(32'h1111_1111 * (k + 1)));
    end
    chk("wr1_we", 64'(log_we[3]), 64'd1);
    chk("wr1_stable", 64'(unstable), 64'd0);
    chk("wr1_ready", 64'(ready_cnt), 64'd1);
    chk("wr1_rbusy", 64'(rb_cnt), 64'd0);
    chk("wr1_wbusy_seen", 64'(wb_cnt > 8), 64'd1);
    chk("wr1_data_kept", 64'(word_of(offchip_mem_data, 0)), 64'h1000);
    ack_mode = 0;

    // Read and write together at 0x3000: write first, then release rule.
    clear_logs();
    offchip_mem_addr     = 32'h0000_3000;
    offchip_mem_read_en  = 1'b1;
    offchip_mem_write_en = 1'b1;
    wait_ready("both", cyc);
    #1 offchip_mem_write_en = 1'b0;
    idle_cycles(20);
    chk("both_first_we", 64'(log_we[0]), 64'd1);
    chk("both_beats_held", 64'(nb), 64'd8);
    chk("both_ready_held", 64'(ready_cnt), 64'd1);
    #1 offchip_mem_read_en = 1'b0;
    @(negedge clk);
    #1 offchip_mem_read_en = 1'b1;
    wait_ready("both_rd", cyc);
    #1 offchip_mem_read_en = 1'b0;
    idle_cycles(3);
    chk("both_beats", 64'(nb), 64'd16);
    chk("both_rd_we", 64'(log_we[8]), 64'd0);
    chk("both_rd_addr", 64'(log_addr[8]), 64'h3000);
    chk("both_word1", 64'(word_of(offchip_mem_data, 1)), 64'h3004);
    chk("both_ready", 64'(ready_cnt), 64'd2);

    // Top-of-memory line.
    clear_logs();
    offchip_mem_addr    = 32'hFFFF_FFF0;
    offchip_mem_read_en = 1'b1;
    wait_ready("top", cyc);
    #1 offchip_mem_read_en = 1'b0;
    idle_cycles(3);
    chk("top_addr0", 64'(log_addr[0]), 64'hFFFF_FFE0);
    chk("top_addr7", 64'(log_addr[7]), 64'hFFFF_FFFC);
    chk("top_word0", 64'(word_of(offchip_mem_data, 0)), 64'hFFFF_FFE0);
    chk("top_word7", 64'(word_of(offchip_mem_data, 7)), 64'hFFFF_FFFC);
    chk("top_beats", 64'(nb), 64'd8);

    // Reset in the middle of a read.
    clear_logs();
    offchip_mem_addr    = 32'h0000_4000;
    offchip_mem_read_en = 1'b1;
    cyc = 0;
    while (nb < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_beat3", 64'(nb), 64'd3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req",   64'(sram_req), 64'd0);
    chk("mid_rst_addr",  64'(sram_addr), 64'd0);
    chk("mid_rst_rbusy", 64'(offchip_mem_read_busy), 64'd0);
    chk("mid_rst_data",  64'(|offchip_mem_data), 64'd0);
    offchip_mem_read_en = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    idle_cycles(3);
    chk("mid_idle_req", 64'(sram_req), 64'd0);
    clear_logs();
    offchip_mem_addr    = 32'h0000_5000;
    offchip_mem_read_en = 1'b1;
    wait_ready("post_rst", cyc);
    chk("post_rst_latency", 64'(cyc), 64'd10);
    #1 offchip_mem_read_en = 1'b0;
    idle_cycles(3);
    chk("post_rst_word0", 64'(word_of(offchip_mem_data, 0)), 64'h5000);
    chk("post_rst_word3", 64'(word_of(offchip_mem_data, 3)), 64'h500C);

    // Request held for 20 cycles after ready.
    clear_logs();
    offchip_mem_addr    = 32'h0000_6000;
    offchip_mem_read_en = 1'b1;
    wait_ready("hold", cyc);
    idle_cycles(20);
    #1 offchip_mem_read_en = 1'b0;
    idle_cycles(3);
    chk("hold_beats", 64'(nb), 64'd8);
    chk("hold_ready", 64'(ready_cnt), 64'd1);
    chk("hold_wide",  64'(wide), 64'd0);
    chk("hold_word5", 64'(word_of(offchip_mem_data, 5)), 64'h6014);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
